vpu_seq: RTL and testbench
==========================

Name: vpu_seq

Overview:
- Vector sequencer for the VPU element ALU (combinational fp32 add/sub/mult-const unit).
- Accepts one vector command over a valid/ready port and streams elements through the ALU, one element per cycle:
  - reads two operand vectors from the vector register file (2 sync read ports);
  - drives the ALU;
  - writes results back through the VRF write port.
- Sits between the instruction dispatcher and the VPU datapath.

Parameters:
- DATA_W, 32, element width (fp32).
- OP_W, 4, opcode width.
- ADDR_W, 8, VRF element address width.
- LEN_W, 8, vector length field width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  sequencer can accept command
- cmd_opcode  in  OP_W  ALU opcode (0 ADD, 1 SUB, 2 MULT_CONST)
- cmd_src0  in  ADDR_W  operand-0 base address
- cmd_src1  in  ADDR_W  operand-1 base address
- cmd_dst  in  ADDR_W  result base address
- cmd_len  in  LEN_W  element count; 0 = no-op
- rd0_en, rd1_en  out  1  VRF read enables
- rd0_addr, rd1_addr  out  ADDR_W  VRF read addresses
- rd0_data, rd1_data  in  DATA_W  VRF read data, valid 1 cycle after rdX_en
- op_start  out  1  ALU start
- op_a, op_b  out  DATA_W  ALU operands
- op_code  out  OP_W  ALU opcode
- op_result  in  DATA_W  ALU result (combinational)
- wr_en  out  1  VRF write enable
- wr_addr  out  ADDR_W  VRF write address
- wr_data  out  DATA_W  VRF write data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = illegal opcode

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; all outputs are 0 except cmd_ready=1.
  - Any latched command is discarded, including mid-vector; in-flight writes are dropped.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, latch opcode, src0, src1, dst and len; index i=0.
  - If len==0 or opcode>2: go to DONE (err=opcode>2). Otherwise go to RUN.
- RUN:
  - Each cycle: rd0_en=rd1_en=1, rd0_addr=src0+i, rd1_addr=src1+i (mod 2^ADDR_W wrap); i increments.
  - After issuing i=len-1, go to DRAIN.
- Pipeline:
  - Stage 1: the cycle after a read, op_start=1, op_a=rd0_data, op_b=rd1_data, op_code=latched opcode.
  - Stage 2: op_result is registered into wr_data; wr_en=1, wr_addr=dst+i (wrap).
  - Write of element i occurs exactly 2 cycles after its read issue.
  - op_start, op_a and op_b are 0 when stage 1 is empty.
- DRAIN: lasts 2 cycles, until the last wr_en; then go to DONE.
- DONE: done=1 for one cycle, cmd_ready=0; next state is IDLE.
- Latency (command accepted in cycle 0, len=N≥1):
  - reads in cycles 1..N;
  - writes in cycles 3..N+2;
  - done in cycle N+3;
  - cmd_ready high again in cycle N+4.
- len==0 or illegal opcode: done in cycle 1; no rd_en or wr_en asserted.
- Hazards:
  - dst==src0/src1 (in-place) is safe.
  - dst-srcX in [3, len-1] (forward overlap) gives undefined results; software must avoid it.
- busy=1 in RUN, DRAIN and DONE.
- Addresses wrap silently at 2^ADDR_W; no error is raised.

Optional Feature:
- Macro: VPU_SEQ_PERF_EN.
- Defined:
  - Adds input perf_clr (1), plus outputs perf_busy_cycles (32) and perf_elems (32).
  - perf_busy_cycles increments each cycle busy=1; perf_elems increments on each wr_en.
  - Both counters saturate at all-ones, reset to 0, and clear synchronously on perf_clr. perf_clr has priority over an increment in the same cycle.
- Undefined: ports and logic are absent.

Decomposition:
- Shared package vpu_pkg holds:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_MULT_CONST=2;
  - the vpu_seq_state_t enum;
  - a vpu_cmd_t struct {opcode, src0, src1, dst, len}.
- One sub-module: vpu_seq_pipe, a 2-stage valid/address shift pipeline carrying wr_addr alongside data.
- The ALU is instantiated outside this block.

Test Plan:
- ADD, len=4, src0=0x10, src1=0x20, dst=0x30, VRF holds 1.0/2.0 → wr at 0x30..0x33 with 3.0 (0x40400000) in cycles 3..6; done in cycle 7; cmd_ready in cycle 8.
- SUB, len=1, operands 5.0 and 2.0 → single wr_data 0x40400000; op_b unchanged on the port, because sign flip happens inside the ALU.
- len=0, then opcode=7 with len=3 → done in cycle 1 both times; err=0 then err=1; zero rd_en/wr_en pulses.
- src0=0xFE, dst=0xFF, len=3 → read addresses 0xFE, 0xFF, 0x00; write addresses 0xFF, 0x00, 0x01.
- rst_n low in cycle 2 of a len=8 command → outputs 0, cmd_ready=1 immediately; no further wr_en; next command runs normally.
- VPU_SEQ_PERF_EN: two len=4 commands → perf_elems=8, perf_busy_cycles=14; perf_clr → both 0 the next cycle.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU vector sequencer: opcodes, FSM states and
// the latched command record.
package vpu_pkg;

  localparam int VPU_DATA_W = 32;
  localparam int VPU_OP_W   = 4;
  localparam int VPU_ADDR_W = 8;
  localparam int VPU_LEN_W  = 8;

  localparam logic [VPU_OP_W-1:0] OP_ADD        = 4'd0;
  localparam logic [VPU_OP_W-1:0] OP_SUB        = 4'd1;
  localparam logic [VPU_OP_W-1:0] OP_MULT_CONST = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } vpu_seq_state_t;

  typedef struct packed {
    logic [VPU_OP_W-1:0]   opcode;
    logic [VPU_ADDR_W-1:0] src0;
    logic [VPU_ADDR_W-1:0] src1;
    logic [VPU_ADDR_W-1:0] dst;
    logic [VPU_LEN_W-1:0]  len;
  } vpu_cmd_t;

  // Legal opcodes are ADD, SUB and MULT_CONST; any larger value is rejected.
  function automatic logic op_legal(input logic [VPU_OP_W-1:0] op);
    return (op <= OP_MULT_CONST);
  endfunction

endpackage

// File: rtl/vpu_seq_pipe.sv
// Two-stage element pipeline: stage 1 marks the cycle the VRF read data
// feeds the ALU, stage 2 registers the ALU result as the VRF write.
// The write address travels alongside the valid bit.
module vpu_seq_pipe
  import vpu_pkg::*;
#(
  parameter int DATA_W = VPU_DATA_W,
  parameter int ADDR_W = VPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              s1_valid,
  input  logic [DATA_W-1:0] result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  logic [ADDR_W-1:0] s1_addr;

  // Advance valid/address each cycle; capture the ALU result into the write stage.
  // NOTE: data registers are reset too, so a reset mid-vector leaves no stale
  // write on the VRF port and every output reads 0 straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      s1_valid <= iss_valid;
      s1_addr  <= iss_addr;
      wr_en    <= s1_valid;
      wr_addr  <= s1_valid ? s1_addr : '0;
      wr_data  <= s1_valid ? result  : '0;
    end
  end

endmodule

// File: rtl/vpu_seq.sv
// Vector sequencer for the VPU element ALU. Accepts one command, issues
// one element read per cycle, and writes each result two cycles later.
// Optional feature macro: VPU_SEQ_PERF_EN adds busy-cycle and element
// performance counters with a synchronous clear.
module vpu_seq
  import vpu_pkg::*;
#(
  parameter int DATA_W = VPU_DATA_W,
  parameter int OP_W   = VPU_OP_W,
  parameter int ADDR_W = VPU_ADDR_W,
  parameter int LEN_W  = VPU_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_src0,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rd0_en,
  output logic              rd1_en,
  output logic [ADDR_W-1:0] rd0_addr,
  output logic [ADDR_W-1:0] rd1_addr,
  input  logic [DATA_W-1:0] rd0_data,
  input  logic [DATA_W-1:0] rd1_data,
  output logic              op_start,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [OP_W-1:0]   op_code,
  input  logic [DATA_W-1:0] op_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
`ifdef VPU_SEQ_PERF_EN
  input  logic              perf_clr,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_elems,
`endif
  output logic              busy,
  output logic              done,
  output logic              err
);

  vpu_seq_state_t    state;
  vpu_cmd_t          cmd_q;
  logic [LEN_W-1:0]  idx;        // index of the next element to issue
  logic              drain_cnt;
  logic              rd_en;
  logic [ADDR_W-1:0] iss_waddr;  // write address paired with the current read
  logic              s1_valid;
  logic              cmd_fire;
  logic              cmd_bad;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign cmd_bad  = !op_legal(cmd_opcode);

  // Control FSM with registered outputs: accepts a command, issues reads, drains, pulses done.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      idx       <= '0;
      drain_cnt <= 1'b0;
      rd_en     <= 1'b0;
      rd0_addr  <= '0;
      rd1_addr  <= '0;
      iss_waddr <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            cmd_q     <= '{cmd_opcode, cmd_src0, cmd_src1, cmd_dst, cmd_len};
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0 || cmd_bad) begin
              // Nothing to stream: report straight away.
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= cmd_bad;
            end else begin
              // Element 0 is issued on the accepting edge.
              state     <= ST_RUN;
              rd_en     <= 1'b1;
              rd0_addr  <= cmd_src0;
              rd1_addr  <= cmd_src1;
              iss_waddr <= cmd_dst;
              idx       <= LEN_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (idx == cmd_q.len) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            rd_en     <= 1'b1;
            rd0_addr  <= cmd_q.src0 + ADDR_W'(idx);
            rd1_addr  <= cmd_q.src1 + ADDR_W'(idx);
            iss_waddr <= cmd_q.dst  + ADDR_W'(idx);
            idx       <= idx + LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          // Two cycles cover the last element's ALU and write stages.
          if (drain_cnt) begin
            state <= ST_DONE;
            done  <= 1'b1;
            err   <= 1'b0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          err       <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rd0_en = rd_en;
  assign rd1_en = rd_en;

  // Stage 1 feeds the ALU directly from the VRF read data; zero when empty.
  assign op_start = s1_valid;
  assign op_a     = s1_valid ? rd0_data     : '0;
  assign op_b     = s1_valid ? rd1_data     : '0;
  assign op_code  = s1_valid ? cmd_q.opcode : '0;

  vpu_seq_pipe #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (rd_en),
    .iss_addr  (iss_waddr),
    .s1_valid  (s1_valid),
    .result    (op_result),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

`ifdef VPU_SEQ_PERF_EN
  // Saturating performance counters; a clear wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles <= '0;
      perf_elems       <= '0;
    end else if (perf_clr) begin
      perf_busy_cycles <= '0;
      perf_elems       <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (wr_en && perf_elems != '1)      perf_elems       <= perf_elems + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vpu_seq.sv
// Directed testbench for vpu_seq with a behavioural VRF and fp32 ALU.
module tb_vpu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [7:0]  cmd_src0, cmd_src1, cmd_dst, cmd_len;
  logic        rd0_en, rd1_en;
  logic [7:0]  rd0_addr, rd1_addr;
  logic [31:0] rd0_data, rd1_data;
  logic        op_start;
  logic [31:0] op_a, op_b;
  logic [3:0]  op_code;
  logic [31:0] op_result;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, err;
`ifdef VPU_SEQ_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_busy_cycles, perf_elems;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vpu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_src0   (cmd_src0),
    .cmd_src1   (cmd_src1),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .rd0_en     (rd0_en),
    .rd1_en     (rd1_en),
    .rd0_addr   (rd0_addr),
    .rd1_addr   (rd1_addr),
    .rd0_data   (rd0_data),
    .rd1_data   (rd1_data),
    .op_start   (op_start),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_code    (op_code),
    .op_result  (op_result),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`ifdef VPU_SEQ_PERF_EN
    .perf_clr         (perf_clr),
    .perf_busy_cycles (perf_busy_cycles),
    .perf_elems       (perf_elems),
`endif
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // ---------------- VRF model: two sync read ports, one write port, preload port
  logic [31:0] vrf [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = 8'h00;
  logic [31:0] pre_data = 32'h0;

  always @(posedge clk) begin
    if (rd0_en) rd0_data <= vrf[rd0_addr];
    if (rd1_en) rd1_data <= vrf[rd1_addr];
    if (wr_en)  vrf[wr_addr] <= wr_data;
    if (pre_en) vrf[pre_addr] <= pre_data;
  end

  // ---------------- fp32 ALU model (normal numbers and zero only)
  function automatic real f2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:0] == 31'h0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return 32'h0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  always_comb begin
    op_result = 32'h0;
    case (op_code)
      4'd0:    op_result = r2f(f2r(op_a) + f2r(op_b));
      4'd1:    op_result = r2f(f2r(op_a) - f2r(op_b));
      4'd2:    op_result = r2f(f2r(op_a) * 2.0);
      default: op_result = 32'h0;
    endcase
  end

  // ---------------- per-cycle logs of one command (index = cycle after accept)
  logic        rd_en_l   [64];
  logic [7:0]  rd0_addr_l[64];
  logic [7:0]  rd1_addr_l[64];
  logic        op_st_l   [64];
  logic [31:0] op_a_l    [64];
  logic [31:0] op_b_l    [64];
  logic [3:0]  op_code_l [64];
  logic        wr_en_l   [64];
  logic [7:0]  wr_addr_l [64];
  logic [31:0] wr_data_l [64];
  logic        err_l     [64];
  logic        busy_l    [64];
  int n_rd, n_wr, n_done, done_cyc, ready_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] d, input logic [7:0] len);
    check("ready_before_cmd", {31'h0, cmd_ready}, 32'h1);
    for (int i = 0; i < 64; i++) begin
      rd_en_l[i] = 1'b0; rd0_addr_l[i] = 8'h0; rd1_addr_l[i] = 8'h0;
      op_st_l[i] = 1'b0; op_a_l[i] = 32'h0; op_b_l[i] = 32'h0; op_code_l[i] = 4'h0;
      wr_en_l[i] = 1'b0; wr_addr_l[i] = 8'h0; wr_data_l[i] = 32'h0;
      err_l[i] = 1'b0; busy_l[i] = 1'b0;
    end
    n_rd = 0; n_wr = 0; n_done = 0; done_cyc = -1; ready_cyc = -1;
    cmd_opcode = op; cmd_src0 = s0; cmd_src1 = s1; cmd_dst = d; cmd_len = len;
    cmd_valid = 1'b1;
    for (int c = 1; c < 64; c++) begin
      tick();
      cmd_valid = 1'b0;
      rd_en_l[c] = rd0_en; rd0_addr_l[c] = rd0_addr; rd1_addr_l[c] = rd1_addr;
      op_st_l[c] = op_start; op_a_l[c] = op_a; op_b_l[c] = op_b; op_code_l[c] = op_code;
      wr_en_l[c] = wr_en; wr_addr_l[c] = wr_addr; wr_data_l[c] = wr_data;
      err_l[c] = err; busy_l[c] = busy;
      if (rd0_en) n_rd++;
      if (wr_en)  n_wr++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (cmd_ready) begin
        ready_cyc = c;
        break;
      end
    end
    if (ready_cyc < 0) check("cmd_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_after;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 4'h0;
    cmd_src0 = 8'h0; cmd_src1 = 8'h0; cmd_dst = 8'h0; cmd_len = 8'h0;
`ifdef VPU_SEQ_PERF_EN
    perf_clr = 1'b0;
`endif
    tick(); tick();

    // Reset state
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_busy",      {31'h0, busy},      32'h0);
    check("rst_done",      {31'h0, done},      32'h0);
    check("rst_rd_wr",     {30'h0, rd0_en, wr_en}, 32'h0);
    check("rst_op_start",  {31'h0, op_start},  32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // ADD len=4: 1.0 + 2.0
    for (int i = 0; i < 4; i++) begin
      poke(8'h10 + 8'(i), 32'h3F800000);
      poke(8'h20 + 8'(i), 32'h40000000);
    end
    run_cmd(4'd0, 8'h10, 8'h20, 8'h30, 8'd4);
    check("add_n_rd",      n_rd, 4);
    check("add_rd_c1",     {31'h0, rd_en_l[1]}, 32'h1);
    check("add_rd_c4",     {31'h0, rd_en_l[4]}, 32'h1);
    check("add_rd0_addr1", {24'h0, rd0_addr_l[1]}, 32'h10);
    check("add_rd0_addr4", {24'h0, rd0_addr_l[4]}, 32'h13);
    check("add_rd1_addr2", {24'h0, rd1_addr_l[2]}, 32'h21);
    check("add_op_start2", {31'h0, op_st_l[2]}, 32'h1);
    check("add_op_a2",     op_a_l[2], 32'h3F800000);
    check("add_op_b5",     op_b_l[5], 32'h40000000);
    check("add_op_start6", {31'h0, op_st_l[6]}, 32'h0);
    check("add_n_wr",      n_wr, 4);
    check("add_wr_c3",     {31'h0, wr_en_l[3]}, 32'h1);
    check("add_wr_c6",     {31'h0, wr_en_l[6]}, 32'h1);
    check("add_wr_addr3",  {24'h0, wr_addr_l[3]}, 32'h30);
    check("add_wr_addr6",  {24'h0, wr_addr_l[6]}, 32'h33);
    check("add_wr_data3",  wr_data_l[3], 32'h40400000);
    check("add_wr_data6",  wr_data_l[6], 32'h40400000);
    check("add_done_cyc",  done_cyc, 7);
    check("add_n_done",    n_done, 1);
    check("add_err",       {31'h0, err_l[7]}, 32'h0);
    check("add_busy7",     {31'h0, busy_l[7]}, 32'h1);
    check("add_ready_cyc", ready_cyc, 8);
    check("add_busy8",     {31'h0, busy_l[8]}, 32'h0);
    check("add_vrf_33",    vrf[8'h33], 32'h40400000);

    // SUB len=1: 5.0 - 2.0, op_b passes through unchanged
    poke(8'h40, 32'h40A00000);
    poke(8'h50, 32'h40000000);
    run_cmd(4'd1, 8'h40, 8'h50, 8'h60, 8'd1);
    check("sub_op_b",     op_b_l[2], 32'h40000000);
    check("sub_op_code",  {28'h0, op_code_l[2]}, 32'h1);
    check("sub_wr_data",  wr_data_l[3], 32'h40400000);
    check("sub_n_wr",     n_wr, 1);
    check("sub_done_cyc", done_cyc, 4);

    // MULT_CONST len=2: x * 2.0
    poke(8'h70, 32'h3FC00000);
    poke(8'h71, 32'h40400000);
    run_cmd(4'd2, 8'h70, 8'h00, 8'h78, 8'd2);
    check("mul_wr_data0", wr_data_l[3], 32'h40400000);
    check("mul_wr_data1", wr_data_l[4], 32'h40C00000);
    check("mul_wr_addr1", {24'h0, wr_addr_l[4]}, 32'h79);

    // len=0: immediate done, no error
    run_cmd(4'd0, 8'h10, 8'h20, 8'h30, 8'd0);
    check("len0_done_cyc", done_cyc, 1);
    check("len0_err",      {31'h0, err_l[1]}, 32'h0);
    check("len0_rd_wr",    n_rd + n_wr, 0);
    check("len0_ready",    ready_cyc, 2);

    // Illegal opcode: immediate done with error
    run_cmd(4'd7, 8'h10, 8'h20, 8'h30, 8'd3);
    check("ill_done_cyc", done_cyc, 1);
    check("ill_err",      {31'h0, err_l[1]}, 32'h1);
    check("ill_rd_wr",    n_rd + n_wr, 0);
    check("ill_err_clr",  {31'h0, err_l[2]}, 32'h0);

    // Address wrap at 2^8
    run_cmd(4'd0, 8'hFE, 8'h80, 8'hFF, 8'd3);
    check("wrap_rd0",  {rd0_addr_l[1], rd0_addr_l[2], rd0_addr_l[3], 8'h0}, 32'hFEFF0000);
    check("wrap_wr",   {wr_addr_l[3], wr_addr_l[4], wr_addr_l[5], 8'h0}, 32'hFF000100);
    check("wrap_n_wr", n_wr, 3);

    // Reset in cycle 2 of a len=8 command
    cmd_opcode = 4'd0; cmd_src0 = 8'h10; cmd_src1 = 8'h20; cmd_dst = 8'hA0; cmd_len = 8'd8;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'h0, cmd_ready}, 32'h1);
    check("mid_rst_busy",  {31'h0, busy}, 32'h0);
    check("mid_rst_rd",    {31'h0, rd0_en}, 32'h0);
    check("mid_rst_op",    op_a | {31'h0, op_start}, 32'h0);
    check("mid_rst_wr",    {31'h0, wr_en}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    wr_after = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (wr_en) wr_after++;
    end
    check("mid_rst_no_wr", wr_after, 0);
    run_cmd(4'd0, 8'h10, 8'h20, 8'h90, 8'd2);
    check("post_rst_done", done_cyc, 5);
    check("post_rst_n_wr", n_wr, 2);
    check("post_rst_data", wr_data_l[4], 32'h40400000);

`ifdef VPU_SEQ_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("perf_clr0_busy", perf_busy_cycles, 32'h0);
    check("perf_clr0_elem", perf_elems, 32'h0);
    run_cmd(4'd0, 8'h10, 8'h20, 8'h30, 8'd4);
    run_cmd(4'd0, 8'h10, 8'h20, 8'h30, 8'd4);
    check("perf_elems", perf_elems, 32'd8);
    check("perf_busy",  perf_busy_cycles, 32'd14);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("perf_clr_busy", perf_busy_cycles, 32'h0);
    check("perf_clr_elem", perf_elems, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
